// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready byte input, FIFO, 8N1 serial line out.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT    = 104,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_i,
    input  logic       tx_i_v,
    output logic       tx_i_rdy,
    output logic       tx_o,
    output logic       busy,
    output logic       overflow
);

    localparam int DEPTH  = 1 << FIFO_ADDR_WIDTH;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]        BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_ADDR_WIDTH:0] FULL_CNT  = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [FIFO_ADDR_WIDTH:0]   count;
    logic                       push, pop, fifo_empty;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              baud_done, tx_d;
`ifdef UART_TX_PARITY_EN
    logic              par_q;
`endif

    // Readiness depends only on occupancy, so a write while full is dropped
    // even when the FSM pops on that same edge.
    assign tx_i_rdy   = (count != FULL_CNT);
    assign fifo_empty = (count == '0);
    assign push       = tx_i_v & tx_i_rdy;
    assign busy       = (state_q != IDLE) | ~fifo_empty;
    assign baud_done  = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tx_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (tx_i_v & ~tx_i_rdy)
                overflow <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next frame with no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase

        // Line level is registered from the next state so it changes with the state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_o    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_o    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
        if (pop)
            par_q <= ^shift_d;
`endif
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: directed pushes queue expected bytes,
// a line monitor reassembles each frame sample-by-sample and compares.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clk;
    logic       rst;
    logic [7:0] tx_i;
    logic       tx_i_v;
    logic       tx_i_rdy;
    logic       tx_o;
    logic       busy;
    logic       overflow;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_ADDR_WIDTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_i     (tx_i),
        .tx_i_v   (tx_i_v),
        .tx_i_rdy (tx_i_rdy),
        .tx_o     (tx_o),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  sb [$];
    int          frames_seen = 0;
    int          last_start  = 0;
    int          last_gap    = 0;
    logic [63:0] last_samples = '0;
    bit          in_frame = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, got, exp);
    endtask

    // Expected line samples for one frame: start, data LSB first, [parity], stop.
    function automatic logic [63:0] frame_samples(input logic [7:0] b);
        logic [10:0] bits;
        logic [63:0] r;
        bits    = '0;
        bits[0] = 1'b0;
        bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
        bits[9]  = ^b;
        bits[10] = 1'b1;
`else
        bits[9]  = 1'b1;
`endif
        r = '0;
        for (int i = 0; i < FRAME_CYC; i++) r[i] = bits[i / CPB];
        return r;
    endfunction

    function automatic logic [63:0] expand(input logic [10:0] bits);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < FRAME_CYC; i++) r[i] = bits[i / CPB];
        return r;
    endfunction

    // Line monitor
    initial begin
        int          nsamp;
        int          idle_run;
        logic [63:0] samples;
        logic [7:0]  exp_b;
        nsamp    = 0;
        idle_run = 0;
        samples  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0;
                idle_run = 0;
            end else if (!in_frame) begin
                if (tx_o === 1'b0) begin
                    in_frame   = 1'b1;
                    samples    = '0;
                    nsamp      = 1;
                    last_start = cyc;
                    last_gap   = idle_run;
                end else begin
                    idle_run++;
                end
            end else begin
                samples[nsamp] = tx_o;
                nsamp++;
                if (nsamp == FRAME_CYC) begin
                    in_frame     = 1'b0;
                    idle_run     = 0;
                    frames_seen++;
                    last_samples = samples;
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_frame: got line pattern %h, required no frame", samples);
                    end else begin
                        exp_b = sb.pop_front();
                        check("frame_bits", samples, frame_samples(exp_b));
                    end
                end
            end
        end
    end

    // Caller sits 1ns after a posedge; byte is presented for exactly one edge.
    task automatic drive_byte(input logic [7:0] b, input bit expect_acc);
        tx_i   = b;
        tx_i_v = 1'b1;
        @(posedge clk);
        #1;
        tx_i_v = 1'b0;
        if (expect_acc) sb.push_back(b);
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while ((busy || in_frame || sb.size() != 0) && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_queue", 64'(sb.size()), 64'd0);
        check("drain_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e;
        int f0;
        rst    = 1'b0;
        tx_i   = 8'h00;
        tx_i_v = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_o", {63'd0, tx_o}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_rdy", {63'd0, tx_i_rdy}, 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single byte 0xA5: latency, exact waveform, busy window
        drive_byte(8'hA5, 1'b1);
        e = cyc;
        repeat (FRAME_CYC) @(posedge clk);
        @(negedge clk);
        check("busy_last_stop", {63'd0, busy}, 64'd1);
        @(negedge clk);
        check("busy_after_frame", {63'd0, busy}, 64'd0);
        check("start_latency", 64'(last_start), 64'(e + 1));
`ifdef UART_TX_PARITY_EN
        check("a5_waveform", last_samples, expand(11'b10101001010));
        check("a5_parity", {63'd0, last_samples[9*CPB]}, 64'd0);
`else
        check("a5_waveform", last_samples, expand(11'b01101001010));
`endif
        @(posedge clk);
        #1;

        // Back-to-back 0x00, 0xFF: no idle gap
        f0 = frames_seen;
        drive_byte(8'h00, 1'b1);
        drive_byte(8'hFF, 1'b1);
        wait_done(1000);
        check("b2b_frames", 64'(frames_seen - f0), 64'd2);
        check("b2b_gap", 64'(last_gap), 64'd0);

        // Overflow: 0x10 popped, 0x11..0x14 fill, 0x15 dropped
        check("ovf_before", {63'd0, overflow}, 64'd0);
        f0 = frames_seen;
        drive_byte(8'h10, 1'b1);
        e = cyc;
        drive_byte(8'h11, 1'b1);
        drive_byte(8'h12, 1'b1);
        drive_byte(8'h13, 1'b1);
        drive_byte(8'h14, 1'b1);
        drive_byte(8'h15, 1'b0);
        check("ovf_set", {63'd0, overflow}, 64'd1);
        check("rdy_full", {63'd0, tx_i_rdy}, 64'd0);
        repeat (FRAME_CYC - 5) @(posedge clk);
        #1;
        check("rdy_full_before_pop", {63'd0, tx_i_rdy}, 64'd0);
        // Offered on the same edge as the pop: still dropped
        drive_byte(8'h55, 1'b0);
        check("rdy_after_pop", {63'd0, tx_i_rdy}, 64'd1);
        wait_done(2000);
        check("ovf_frames", 64'(frames_seen - f0), 64'd5);
        check("ovf_sticky", {63'd0, overflow}, 64'd1);

        // Reset mid-frame while the line is low
        drive_byte(8'h3C, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check("pre_rst_line_low", {63'd0, tx_o}, 64'd0);
        sb.delete();
        #2 rst = 1'b1;
        #1;
        check("midrst_tx_o", {63'd0, tx_o}, 64'd1);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_rdy", {63'd0, tx_i_rdy}, 64'd1);
        check("midrst_overflow", {63'd0, overflow}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        f0 = frames_seen;
        repeat (30) @(posedge clk);
        #1;
        check("postrst_frames", 64'(frames_seen - f0), 64'd0);
        check("postrst_line", {63'd0, tx_o}, 64'd1);
        check("postrst_busy", {63'd0, busy}, 64'd0);

        // Push and pop on the same edge at two entries
        f0 = frames_seen;
        drive_byte(8'h3A, 1'b1);
        e = cyc;
        drive_byte(8'hB4, 1'b1);
        drive_byte(8'hC7, 1'b1);
        repeat (FRAME_CYC - 2) @(posedge clk);
        #1;
        drive_byte(8'h5D, 1'b1);
        drive_byte(8'h6E, 1'b1);
        drive_byte(8'h7F, 1'b1);
        check("rdy_full_after_pushpop", {63'd0, tx_i_rdy}, 64'd0);
        wait_done(3000);
        check("pushpop_frames", 64'(frames_seen - f0), 64'd6);
        check("pushpop_overflow", {63'd0, overflow}, 64'd0);

`ifdef UART_TX_PARITY_EN
        drive_byte(8'h01, 1'b1);
        wait_done(1000);
        check("p01_parity", {63'd0, last_samples[9*CPB]}, 64'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
